param_shift_reg: RTL and testbench

- Parametrised universal shift register. It generalises the team's fixed 8-bit SISO/SIPO/rotate register to WIDTH bits.
- Adds per-cycle mode select (hold, logical/arithmetic shift, rotate, parallel load, clear), a clock enable, dual serial outputs, and a shift-frame counter.
- Used as a serialiser/deserialiser front end for serial links and bit-manipulation datapaths.

---
 rtl/param_shift_reg_if.sv | 52 +++++
 rtl/param_shift_reg.sv | 125 ++++++++++++
 tb/tb_param_shift_reg.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_shift_reg_if.sv
// -----------------------------------------------------------------------------
// param_shift_reg_if
// Groups the control, data and status signals of param_shift_reg.
//   en          clock enable (0 = full hold of all state)
//   mode        3-bit operation select
//   sin         serial data in
//   pin         parallel load data
//   pout        register contents q
//   sout_l      q[WIDTH-1], next bit out on a left shift
//   sout_r      q[0], next bit out on a right shift
//   shift_cnt   shift/rotate ops since last load/clear/frame end
//   frame_done  one-cycle pulse when WIDTH shift/rotate ops have completed
// master: drives controls, observes status. slave: the shift register.
// -----------------------------------------------------------------------------
interface param_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout_l;
    logic             sout_r;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    modport master (
        output en,
        output mode,
        output sin,
        output pin,
        input  pout,
        input  sout_l,
        input  sout_r,
        input  shift_cnt,
        input  frame_done
    );

    modport slave (
        input  en,
        input  mode,
        input  sin,
        input  pin,
        output pout,
        output sout_l,
        output sout_r,
        output shift_cnt,
        output frame_done
    );
endinterface

// File: rtl/param_shift_reg.sv
// -----------------------------------------------------------------------------
// param_shift_reg
// Parametrised universal shift register with per-cycle mode select, clock
// enable, dual serial outputs and a shift-frame counter.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-high
//   bus_if  slave side of param_shift_reg_if (en, mode, sin, pin in;
//           pout, sout_l, sout_r, shift_cnt, frame_done out)
// Modes: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD, 6 ASR, 7 CLR.
// WIDTH legal range is 2..64; CNT_W is derived and must not be overridden.
// -----------------------------------------------------------------------------
module param_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    param_shift_reg_if.slave        bus_if
);

    typedef enum logic [2:0] {
        ModeHold = 3'd0,
        ModeShl  = 3'd1,
        ModeShr  = 3'd2,
        ModeRol  = 3'd3,
        ModeRor  = 3'd4,
        ModeLoad = 3'd5,
        ModeAsr  = 3'd6,
        ModeClr  = 3'd7
    } mode_e;

    // Count value on which the next shift op completes a frame.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;

    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_frame_done_next;
    logic             w_is_shift;
    logic             w_is_restart;

    // Data path: next register contents for the selected mode.
    always_comb begin
        w_q_next     = r_q;
        w_is_shift   = 1'b0;
        w_is_restart = 1'b0;
        case (mode_e'(bus_if.mode))
            ModeHold: begin
                w_q_next = r_q;
            end
            ModeShl: begin
                w_q_next   = {r_q[WIDTH-2:0], bus_if.sin};
                w_is_shift = 1'b1;
            end
            ModeShr: begin
                w_q_next   = {bus_if.sin, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            ModeRol: begin
                w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            ModeRor: begin
                w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            ModeLoad: begin
                w_q_next     = bus_if.pin;
                w_is_restart = 1'b1;
            end
            ModeAsr: begin
                w_q_next   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            ModeClr: begin
                w_q_next     = '0;
                w_is_restart = 1'b1;
            end
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    // Frame counter: every shift/rotate counts regardless of direction; the
    // WIDTH-th op wraps the count and raises frame_done for one enabled cycle.
    always_comb begin
        w_cnt_next        = r_cnt;
        w_frame_done_next = 1'b0;
        if (w_is_shift) begin
            if (r_cnt == CntLast) begin
                w_cnt_next        = '0;
                w_frame_done_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else if (w_is_restart) begin
            w_cnt_next = '0;
        end
    end

    // en=0 freezes everything, including a pending frame_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (bus_if.en) begin
            r_q          <= w_q_next;
            r_cnt        <= w_cnt_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign bus_if.pout       = r_q;
    assign bus_if.sout_l     = r_q[WIDTH-1];
    assign bus_if.sout_r     = r_q[0];
    assign bus_if.shift_cnt  = r_cnt;
    assign bus_if.frame_done = r_frame_done;

endmodule

// File: tb/tb_param_shift_reg.sv
module tb_param_shift_reg;

    localparam logic [2:0] HOLD = 3'd0;
    localparam logic [2:0] SHL  = 3'd1;
    localparam logic [2:0] SHR  = 3'd2;
    localparam logic [2:0] ROL  = 3'd3;
    localparam logic [2:0] ROR  = 3'd4;
    localparam logic [2:0] LOAD = 3'd5;
    localparam logic [2:0] ASR  = 3'd6;
    localparam logic [2:0] CLR  = 3'd7;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  mode;
    logic        sin;
    logic [63:0] pin;

    int n_checks;
    int n_pass;

    // Three instances (WIDTH 8, 2, 32) share one stimulus stream.
    param_shift_reg_if #(.WIDTH(8))  if8 ();
    param_shift_reg_if #(.WIDTH(2))  if2 ();
    param_shift_reg_if #(.WIDTH(32)) if32 ();

    assign if8.en   = en;
    assign if8.mode = mode;
    assign if8.sin  = sin;
    assign if8.pin  = pin[7:0];
    assign if2.en   = en;
    assign if2.mode = mode;
    assign if2.sin  = sin;
    assign if2.pin  = pin[1:0];
    assign if32.en   = en;
    assign if32.mode = mode;
    assign if32.sin  = sin;
    assign if32.pin  = pin[31:0];

    param_shift_reg #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus_if(if8));
    param_shift_reg #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus_if(if2));
    param_shift_reg #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus_if(if32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int          widths [3] = '{8, 2, 32};
    logic [63:0] m_q    [3] = '{64'd0, 64'd0, 64'd0};
    int          m_cnt  [3] = '{0, 0, 0};
    bit          m_fd   [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Register value after one op, as plain arithmetic on an integer.
    function automatic logic [63:0] model_next(input logic [63:0] q, input int w,
                                               input logic [2:0] m, input logic s,
                                               input logic [63:0] p);
        logic [63:0] msk;
        logic        top;
        msk = mask_of(w);
        top = q[w-1];
        case (m)
            SHL:     return ((q << 1) | 64'(s)) & msk;
            SHR:     return (q >> 1) | (64'(s) << (w - 1));
            ROL:     return ((q << 1) | 64'(top)) & msk;
            ROR:     return (q >> 1) | (64'(q[0]) << (w - 1));
            ASR:     return (q >> 1) | (64'(top) << (w - 1));
            LOAD:    return p & msk;
            CLR:     return 64'd0;
            default: return q;
        endcase
    endfunction

    function automatic bit is_shift(input logic [2:0] m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_q[k]   <= 64'd0;
                m_cnt[k] <= 0;
                m_fd[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < 3; k++) begin
                m_q[k] <= model_next(m_q[k], widths[k], mode, sin, pin);
                if (is_shift(mode)) begin
                    if (m_cnt[k] + 1 == widths[k]) begin
                        m_cnt[k] <= 0;
                        m_fd[k]  <= 1'b1;
                    end else begin
                        m_cnt[k] <= m_cnt[k] + 1;
                        m_fd[k]  <= 1'b0;
                    end
                end else begin
                    if (mode == LOAD || mode == CLR) m_cnt[k] <= 0;
                    m_fd[k] <= 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cmp_model(input int k, input string tag, input logic [63:0] p,
                             input logic sl, input logic sr, input logic [63:0] c,
                             input logic fd);
        chk({tag, " pout"}, p, m_q[k]);
        chk({tag, " sout_l"}, 64'(sl), 64'(m_q[k][widths[k]-1]));
        chk({tag, " sout_r"}, 64'(sr), 64'(m_q[k][0]));
        chk({tag, " shift_cnt"}, c, 64'(m_cnt[k]));
        chk({tag, " frame_done"}, 64'(fd), 64'(m_fd[k]));
    endtask

    always @(negedge clk) begin
        cmp_model(0, "w8", 64'(if8.pout), if8.sout_l, if8.sout_r,
                  64'(if8.shift_cnt), if8.frame_done);
        cmp_model(1, "w2", 64'(if2.pout), if2.sout_l, if2.sout_r,
                  64'(if2.shift_cnt), if2.frame_done);
        cmp_model(2, "w32", 64'(if32.pout), if32.sout_l, if32.sout_r,
                  64'(if32.shift_cnt), if32.frame_done);
    end

    // ---------------- stimulus helpers ----------------
    // Apply inputs at the falling edge; they take effect at the next rising edge.
    task automatic cyc(input logic e, input logic [2:0] m, input logic s,
                       input logic [63:0] p);
        @(negedge clk);
        en   = e;
        mode = m;
        sin  = s;
        pin  = p;
    endtask

    // Wait until just after the rising edge that consumed the last cyc.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] piso_seq;
    logic [7:0] sipo_seq;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst  = 1'b0;
        en   = 1'b0;
        mode = HOLD;
        sin  = 1'b0;
        pin  = 64'd0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset pout", 64'(if8.pout), 64'h0);
        chk("reset cnt", 64'(if8.shift_cnt), 64'h0);
        #1 rst = 1'b0;

        // Asynchronous reset mid-frame with q=A5, count 3.
        cyc(1'b1, LOAD, 1'b0, 64'h14);
        cyc(1'b1, SHL, 1'b1, 64'h0);
        cyc(1'b1, SHL, 1'b0, 64'h0);
        cyc(1'b1, SHL, 1'b1, 64'h0);
        settle();
        chk("pre-reset q", 64'(if8.pout), 64'hA5);
        chk("pre-reset cnt", 64'(if8.shift_cnt), 64'd3);
        rst = 1'b1;
        #1;
        chk("async reset q", 64'(if8.pout), 64'h0);
        chk("async reset cnt", 64'(if8.shift_cnt), 64'h0);
        chk("async reset fd", 64'(if8.frame_done), 64'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // PISO: serial-out sequence of B4, MSB first.
        piso_seq = 8'hB4;
        cyc(1'b1, LOAD, 1'b0, 64'hB4);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, SHL, 1'b0, 64'h0);
            chk("piso sout_l", 64'(if8.sout_l), 64'(piso_seq[7-i]));
            if (i == 7) chk("piso fd before 8th", 64'(if8.frame_done), 64'h0);
        end
        settle();
        chk("piso q end", 64'(if8.pout), 64'h0);
        chk("piso fd 8th", 64'(if8.frame_done), 64'h1);
        chk("piso w2 fd", 64'(if2.frame_done), 64'h1);
        cyc(1'b1, HOLD, 1'b0, 64'h0);
        settle();
        chk("piso fd after", 64'(if8.frame_done), 64'h0);

        // SIPO via SHR.
        sipo_seq = 8'b1100_1010;
        cyc(1'b1, CLR, 1'b0, 64'h0);
        for (int i = 0; i < 8; i++) cyc(1'b1, SHR, sipo_seq[7-i], 64'h0);
        settle();
        chk("sipo q", 64'(if8.pout), 64'h53);
        chk("sipo fd", 64'(if8.frame_done), 64'h1);

        // Rotates and arithmetic shift.
        cyc(1'b1, LOAD, 1'b0, 64'h81);
        cyc(1'b1, ROL, 1'b1, 64'h0);
        settle();
        chk("rol 81", 64'(if8.pout), 64'h03);
        cyc(1'b1, LOAD, 1'b0, 64'h81);
        cyc(1'b1, ROR, 1'b0, 64'h0);
        settle();
        chk("ror 81", 64'(if8.pout), 64'hC0);
        cyc(1'b1, LOAD, 1'b0, 64'h90);
        cyc(1'b1, ASR, 1'b0, 64'h0);
        settle();
        chk("asr 1", 64'(if8.pout), 64'hC8);
        cyc(1'b1, ASR, 1'b1, 64'h0);
        settle();
        chk("asr 2", 64'(if8.pout), 64'hE4);

        // Enable / hold.
        cyc(1'b1, LOAD, 1'b0, 64'h0F);
        repeat (3) cyc(1'b1, SHL, 1'b0, 64'h0);
        repeat (5) cyc(1'b0, 3'bxxx, 1'bx, 64'h0);
        settle();
        chk("en=0 q", 64'(if8.pout), 64'h78);
        chk("en=0 cnt", 64'(if8.shift_cnt), 64'd3);
        repeat (2) cyc(1'b1, HOLD, 1'b0, 64'h0);
        settle();
        chk("hold cnt", 64'(if8.shift_cnt), 64'd3);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, SHL, 1'b0, 64'h0);
            settle();
            chk("resume fd", 64'(if8.frame_done), (i == 4) ? 64'h1 : 64'h0);
        end
        repeat (2) cyc(1'b0, SHL, 1'b0, 64'h0);
        settle();
        chk("fd held en=0", 64'(if8.frame_done), 64'h1);
        cyc(1'b1, HOLD, 1'b0, 64'h0);
        settle();
        chk("fd cleared", 64'(if8.frame_done), 64'h0);

        // Frame abort.
        repeat (4) cyc(1'b1, SHL, 1'b1, 64'h0);
        cyc(1'b1, LOAD, 1'b0, 64'h3C);
        settle();
        chk("abort cnt", 64'(if8.shift_cnt), 64'h0);
        chk("abort fd", 64'(if8.frame_done), 64'h0);

        // WIDTH=32 PISO frame.
        cyc(1'b1, LOAD, 1'b0, 64'h8000_00B4);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, SHL, 1'b0, 64'h0);
            settle();
            if (i == 30) chk("w32 fd at 31", 64'(if32.frame_done), 64'h0);
        end
        chk("w32 fd at 32", 64'(if32.frame_done), 64'h1);
        chk("w32 q end", 64'(if32.pout), 64'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] m;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                @(negedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end else begin
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 4))
                        0:       m = SHL;
                        1:       m = SHR;
                        2:       m = ROL;
                        3:       m = ROR;
                        default: m = ASR;
                    endcase
                end else begin
                    m = 3'($urandom_range(0, 7));
                end
                cyc((r < 85) ? 1'b1 : 1'b0, m, 1'($urandom_range(0, 1)),
                    {$urandom, $urandom});
            end
        end
        settle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
